// File: rtl/clock_divider_pkg.sv
// ----------------------------------------------------------------------------
// Package: clock_divider_pkg
// Purpose: Shared types and helpers for the multi-channel clock divider.
//   chan_state_e : per-channel run state (IDLE, RUN, STOP)
//   DIV_MIN      : smallest effective divisor a running channel can use
//   eff_div()    : maps a programmed divisor to the effective period length
//                  (0 -> 0 = hold idle, 1 -> DIV_MIN, otherwise unchanged)
// ----------------------------------------------------------------------------
package clock_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } chan_state_e;

    localparam int unsigned DIV_MIN = 2;

    function automatic int unsigned eff_div(input int unsigned div);
        if (div == 0)
            return 0;
        else if (div == 1)
            return DIV_MIN;
        else
            return div;
    endfunction

endpackage

// File: rtl/clock_divider_chan.sv
// ----------------------------------------------------------------------------
// Module: clock_divider_chan
// Purpose: One programmable integer clock divider channel. The divisor is
//   latched only at period starts so a retune never produces a glitch, a
//   stop request always completes the current period, and a sync strobe
//   restarts a running channel at the beginning of a fresh period.
// Optional feature: define CLKDIV_ODD_50_EN for exact 50% duty on odd
//   divisors (adds one falling-edge flop and an OR on the output).
// Ports:
//   clock      in   reference clock
//   reset      in   synchronous, active-high reset
//   en         in   run enable
//   div        in   programmed divisor (DIV_W bits)
//   sync       in   1-cycle restart strobe
//   clock_out  out  divided clock
//   tick       out  1-cycle pulse on each divided rising edge
//   running    out  channel is in RUN or STOP
// ----------------------------------------------------------------------------
module clock_divider_chan
    import clock_divider_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             sync,
    output logic             clock_out,
    output logic             tick,
    output logic             running
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    chan_state_e      state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] n_q, n_d;
    logic             out_q, out_d;
    logic             tick_q, tick_d;

    logic [DIV_W-1:0] n_new;
    logic [DIV_W-1:0] cnt_inc;
    logic [DIV_W-1:0] high_len;
    logic             go;
    logic             terminal;
    logic             restart;

    assign n_new    = DIV_W'(eff_div(32'(div)));
    assign go       = en && (div != '0);
    assign cnt_inc  = cnt_q + ONE;
    assign terminal = (cnt_q == n_q - ONE);

    // A zero divisor while running is a stop request, so restart needs go.
    // A stop request arriving together with sync wins over the sync.
    assign restart  = go && (terminal || (state_q == RUN && sync));

`ifdef CLKDIV_ODD_50_EN
    // The falling-edge half cycle supplies the missing 0.5, so the
    // posedge phase only stays high for floor(N/2) cycles.
    assign high_len = n_q >> 1;
`else
    assign high_len = (n_q >> 1) + DIV_W'(n_q[0]);
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        out_d   = 1'b0;
        tick_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    n_d     = n_new;
                    out_d   = 1'b1;
                    tick_d  = 1'b1;
                end
            end
            RUN, STOP: begin
                if (restart) begin
                    // Wrap and sync share this path: one new period, one tick.
                    state_d = RUN;
                    cnt_d   = '0;
                    n_d     = n_new;
                    out_d   = 1'b1;
                    tick_d  = 1'b1;
                end else if (terminal) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    // Mid-period the enable only selects RUN/STOP; the
                    // period itself always runs to completion.
                    state_d = go ? RUN : STOP;
                    cnt_d   = cnt_inc;
                    out_d   = (cnt_inc < high_len);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            out_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            out_q   <= out_d;
            tick_q  <= tick_d;
        end
    end

`ifdef CLKDIV_ODD_50_EN
    logic out_neg_q;

    // Half-cycle retimed copy stretches the high phase by 0.5 for odd N only.
    always_ff @(negedge clock) begin
        if (reset)
            out_neg_q <= 1'b0;
        else
            out_neg_q <= out_q & n_q[0];
    end

    assign clock_out = out_q | out_neg_q;
`else
    assign clock_out = out_q;
`endif

    assign tick    = tick_q;
    assign running = (state_q != IDLE);

endmodule

// File: rtl/clock_divider_multi.sv
// ----------------------------------------------------------------------------
// Module: clock_divider_multi
// Purpose: NCH independent programmable integer clock dividers, all derived
//   from one reference clock and sharing a common resync strobe.
// Optional feature: CLKDIV_ODD_50_EN (exact 50% duty for odd divisors).
// Ports:
//   clock         in   reference clock
//   reset         in   synchronous, active-high reset
//   io_en         in   [NCH]        per-channel run enable
//   io_div        in   [NCH*DIV_W]  per-channel divisor, channel c at [c*DIV_W +: DIV_W]
//   io_sync       in   1-cycle strobe restarting every running channel
//   io_clock_out  out  [NCH]        divided clocks
//   io_tick       out  [NCH]        1-cycle pulse when io_clock_out[c] rises
//   io_running    out  [NCH]        channel in RUN or STOP
// ----------------------------------------------------------------------------
module clock_divider_multi #(
    parameter int NCH   = 4,
    parameter int DIV_W = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NCH-1:0]       io_en,
    input  logic [NCH*DIV_W-1:0] io_div,
    input  logic                 io_sync,
    output logic [NCH-1:0]       io_clock_out,
    output logic [NCH-1:0]       io_tick,
    output logic [NCH-1:0]       io_running
);

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        clock_divider_chan #(
            .DIV_W(DIV_W)
        ) u_chan (
            .clock    (clock),
            .reset    (reset),
            .en       (io_en[c]),
            .div      (io_div[c*DIV_W +: DIV_W]),
            .sync     (io_sync),
            .clock_out(io_clock_out[c]),
            .tick     (io_tick[c]),
            .running  (io_running[c])
        );
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// ----------------------------------------------------------------------------
// Testbench: tb_clock_divider_multi
// Reference model: each channel owns a queue holding the remaining output
// levels of its current period. A period start fills the queue with
// ceil(N/2) ones then floor(N/2) zeros; every edge pops one level; an empty
// queue marks the end of the period.
// ----------------------------------------------------------------------------
module tb_clock_divider_multi;

    localparam int NCH   = 4;
    localparam int DIV_W = 8;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [NCH-1:0]       io_en;
    logic [NCH*DIV_W-1:0] io_div;
    logic                 io_sync;
    logic [NCH-1:0]       io_clock_out;
    logic [NCH-1:0]       io_tick;
    logic [NCH-1:0]       io_running;

    int checks   = 0;
    int failures = 0;

    clock_divider_multi #(
        .NCH  (NCH),
        .DIV_W(DIV_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .io_en       (io_en),
        .io_div      (io_div),
        .io_sync     (io_sync),
        .io_clock_out(io_clock_out),
        .io_tick     (io_tick),
        .io_running  (io_running)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    bit             q_m[NCH][$];
    bit             live_m[NCH];
    bit             stop_m[NCH];
    logic [NCH-1:0] m_out  = '0;
    logic [NCH-1:0] m_tick = '0;
    logic [NCH-1:0] m_run  = '0;

    task automatic start_period(input int c, input int n);
        q_m[c].delete();
        for (int i = 0; i < n; i++)
            q_m[c].push_back(i < (n + 1) / 2);
        m_out[c]  = q_m[c].pop_front();
        m_tick[c] = 1'b1;
        live_m[c] = 1'b1;
        stop_m[c] = 1'b0;
    endtask

    task automatic model_edge();
        for (int c = 0; c < NCH; c++) begin
            int  d;
            int  n;
            bit  go;
            d  = int'(io_div[c*DIV_W +: DIV_W]);
            n  = (d == 1) ? 2 : d;
            go = io_en[c] && (d != 0);
            m_tick[c] = 1'b0;
            if (reset) begin
                q_m[c].delete();
                live_m[c] = 1'b0;
                stop_m[c] = 1'b0;
                m_out[c]  = 1'b0;
            end else if (!live_m[c]) begin
                if (go) start_period(c, n);
                else    m_out[c] = 1'b0;
            end else if (go && (q_m[c].size() == 0 || (io_sync && !stop_m[c]))) begin
                start_period(c, n);
            end else if (q_m[c].size() == 0) begin
                live_m[c] = 1'b0;
                stop_m[c] = 1'b0;
                m_out[c]  = 1'b0;
            end else begin
                m_out[c]  = q_m[c].pop_front();
                stop_m[c] = !go;
            end
            m_run[c] = live_m[c];
        end
    endtask

    // One reference edge: model sees the same inputs the DUT samples,
    // outputs are compared 1 time unit later.
    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic set_div(input int c, input int v);
        io_div[c*DIV_W +: DIV_W] = DIV_W'(v);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        io_en   = '0;
        io_sync = 1'b0;
        step();
        reset   = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset   = 1'b1;
        io_en   = '1;
        io_div  = '0;
        io_sync = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({io_clock_out, io_tick, io_running} !== '0) begin
                failures++;
                $display("FAIL reset_state cyc=%0d got=%b/%b/%b want=0/0/0",
                         i, io_clock_out, io_tick, io_running);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int ticks0 = 0;
        do_reset();
        for (int c = 1; c < NCH; c++) set_div(c, $urandom_range(1, 9));
        set_div(0, 4);
        io_en = 4'b0001;
        for (int i = 0; i < 16; i++) begin
            step();
            ticks0 += int'(io_tick[0]);
            checks++;
            if ({io_clock_out, io_tick, io_running} !== {m_out, m_tick, m_run}) begin
                failures++;
                $display("FAIL basic_model cyc=%0d got=%b/%b/%b want=%b/%b/%b", i,
                         io_clock_out, io_tick, io_running, m_out, m_tick, m_run);
            end
            checks++;
            if (io_clock_out !== {3'b000, (i % 4) < 2} || io_running !== 4'b0001) begin
                failures++;
                $display("FAIL basic_pattern cyc=%0d got out=%b run=%b want out0=%0d run=0001",
                         i, io_clock_out, io_running, (i % 4) < 2);
            end
        end
        checks++;
        if (ticks0 !== 4) begin
            failures++;
            $display("FAIL basic_tick_count got=%0d want=4", ticks0);
        end
    endtask

    task automatic test_odd();
        int highs = 0;
        do_reset();
        set_div(0, 5);
        io_en = 4'b0001;
        for (int i = 0; i < 15; i++) begin
            step();
            if (i < 5) highs += int'(io_clock_out[0]);
            checks++;
            if ({io_clock_out, io_tick, io_running} !== {m_out, m_tick, m_run}) begin
                failures++;
                $display("FAIL odd_model cyc=%0d got=%b/%b/%b want=%b/%b/%b", i,
                         io_clock_out, io_tick, io_running, m_out, m_tick, m_run);
            end
        end
        checks++;
        if (highs !== 3) begin
            failures++;
            $display("FAIL odd_high_len got=%0d want=3", highs);
        end
    endtask

    task automatic test_retune();
        int tick_cyc[$];
        do_reset();
        set_div(0, 4);
        io_en = 4'b0001;
        for (int i = 0; i < 18; i++) begin
            step();
            if (io_tick[0]) tick_cyc.push_back(i);
            if (i == 0) set_div(0, 6);
            checks++;
            if ({io_clock_out, io_tick, io_running} !== {m_out, m_tick, m_run}) begin
                failures++;
                $display("FAIL retune_model cyc=%0d got=%b/%b/%b want=%b/%b/%b", i,
                         io_clock_out, io_tick, io_running, m_out, m_tick, m_run);
            end
        end
        checks++;
        if (tick_cyc.size() < 3 || tick_cyc[1] !== 4 || tick_cyc[2] !== 10) begin
            failures++;
            $display("FAIL retune_ticks got=%p want=[0,4,10,16]", tick_cyc);
        end
    endtask

    task automatic test_stop();
        int highs = 0;
        int runs  = 0;
        do_reset();
        set_div(0, 8);
        io_en = 4'b0001;
        for (int i = 0; i < 14; i++) begin
            step();
            if (i == 1) io_en = 4'b0000;
            highs += int'(io_clock_out[0]);
            runs  += int'(io_running[0]);
            checks++;
            if ({io_clock_out, io_tick, io_running} !== {m_out, m_tick, m_run}) begin
                failures++;
                $display("FAIL stop_model cyc=%0d got=%b/%b/%b want=%b/%b/%b", i,
                         io_clock_out, io_tick, io_running, m_out, m_tick, m_run);
            end
        end
        checks++;
        if (highs !== 4 || runs !== 8) begin
            failures++;
            $display("FAIL stop_lengths got high=%0d run=%0d want high=4 run=8", highs, runs);
        end
    endtask

    task automatic test_sync();
        int pre;
        do_reset();
        set_div(0, 4);
        set_div(1, 6);
        io_en = 4'b0011;
        pre   = $urandom_range(3, 12);
        for (int i = 0; i < pre + 12; i++) begin
            io_sync = (i == pre);
            step();
            checks++;
            if ({io_clock_out, io_tick, io_running} !== {m_out, m_tick, m_run}) begin
                failures++;
                $display("FAIL sync_model cyc=%0d got=%b/%b/%b want=%b/%b/%b", i,
                         io_clock_out, io_tick, io_running, m_out, m_tick, m_run);
            end
            if (i == pre) begin
                checks++;
                if (io_tick[1:0] !== 2'b11 || io_clock_out[1:0] !== 2'b11) begin
                    failures++;
                    $display("FAIL sync_align got tick=%b out=%b want 11/11",
                             io_tick[1:0], io_clock_out[1:0]);
                end
            end
        end
        io_sync = 1'b0;
    endtask

    task automatic test_div_edges();
        do_reset();
        set_div(0, 1);
        io_en = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (io_clock_out[0] !== ((i % 2) == 0) || io_tick[0] !== ((i % 2) == 0)) begin
                failures++;
                $display("FAIL div1_pattern cyc=%0d got out=%b tick=%b want=%0d",
                         i, io_clock_out[0], io_tick[0], (i % 2) == 0);
            end
        end
        do_reset();
        set_div(0, 0);
        io_en = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (io_clock_out[0] !== 1'b0 || io_running[0] !== 1'b0) begin
                failures++;
                $display("FAIL div0_idle cyc=%0d got out=%b run=%b want 0/0",
                         i, io_clock_out[0], io_running[0]);
            end
        end
        do_reset();
        set_div(0, 4);
        io_en = 4'b0001;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (io_clock_out[0] !== 1'b0 || io_running[0] !== 1'b0 || io_tick[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_high got out=%b run=%b tick=%b want 0/0/0",
                     io_clock_out[0], io_running[0], io_tick[0]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < NCH; c++) set_div(c, $urandom_range(0, 9));
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) io_en = NCH'($urandom);
            if ($urandom_range(0, 5) == 0) set_div($urandom_range(0, NCH - 1), $urandom_range(0, 9));
            io_sync = ($urandom_range(0, 15) == 0);
            reset   = ($urandom_range(0, 79) == 0);
            step();
            checks++;
            if ({io_clock_out, io_tick, io_running} !== {m_out, m_tick, m_run}) begin
                failures++;
                $display("FAIL random_model cyc=%0d got=%b/%b/%b want=%b/%b/%b", i,
                         io_clock_out, io_tick, io_running, m_out, m_tick, m_run);
            end
        end
        reset   = 1'b0;
        io_sync = 1'b0;
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) begin
            live_m[c] = 1'b0;
            stop_m[c] = 1'b0;
        end
        test_reset();
        test_basic();
        test_odd();
        test_retune();
        test_stop();
        test_sync();
        test_div_edges();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
